// File: rtl/sum_display_pkg.sv
// Shared types and constants for the sum_display block: FSM states,
// conversion length and active-low seven-segment codes.
package sum_display_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        FINISH
    } state_t;

    localparam int unsigned NUM_SHIFTS = 5;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/sum_display_seg7.sv
// Combinational BCD-digit to active-low seven-segment decoder (bit0=a .. bit6=g).
module seg7_decode
    import sum_display_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/sum_display.sv
// Converts a 5-bit adder result to two seven-segment digits using a
// sequential double-dabble; displays update once per conversion.
module sum_display
    import sum_display_pkg::*;
#(
    parameter int BLANK_LEADING = 1
) (
    input  logic       CLOCK_50,
    input  logic       RESET,
    input  logic [4:0] SUM,
    input  logic       LOAD,
    output logic       BUSY,
    output logic       DONE,
    output logic [6:0] HEX1,
    output logic [6:0] HEX0
);

    state_t      state, next_state;
    logic [4:0]  sr;
    logic [7:0]  bcd;
    logic [7:0]  bcd_adj;
    logic [2:0]  cnt;
    logic [6:0]  seg_tens, seg_units;

    seg7_decode u_tens  (.digit(bcd[7:4]), .seg(seg_tens));
    seg7_decode u_units (.digit(bcd[3:0]), .seg(seg_units));

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (LOAD) next_state = SHIFT;
            SHIFT:   if (cnt == 3'(NUM_SHIFTS - 1)) next_state = FINISH;
            FINISH:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Add-3 correction applied before each shift of {bcd, sr}
    always_comb begin
        bcd_adj[3:0] = (bcd[3:0] >= 4'd5) ? bcd[3:0] + 4'd3 : bcd[3:0];
        bcd_adj[7:4] = (bcd[7:4] >= 4'd5) ? bcd[7:4] + 4'd3 : bcd[7:4];
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
            BUSY  <= 1'b0;
            DONE  <= 1'b0;
            HEX1  <= SEG_BLANK;
            HEX0  <= SEG_BLANK;
            sr    <= '0;
            bcd   <= '0;
            cnt   <= '0;
        end else begin
            state <= next_state;
            BUSY  <= (next_state != IDLE);
            DONE  <= 1'b0;
            case (state)
                IDLE: begin
                    if (LOAD) begin
                        sr  <= SUM;
                        bcd <= '0;
                        cnt <= '0;
                    end
                end
                SHIFT: begin
                    bcd <= {bcd_adj[6:0], sr[4]};
                    sr  <= {sr[3:0], 1'b0};
                    cnt <= cnt + 3'd1;
                end
                FINISH: begin
                    HEX1 <= (BLANK_LEADING != 0 && bcd[7:4] == 4'd0) ? SEG_BLANK : seg_tens;
                    HEX0 <= seg_units;
                    DONE <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sum_display.sv
// Self-checking bench for sum_display: two instances (leading-zero blanking
// on and off) share stimulus and are compared against a decimal model.
module tb_sum_display;

    logic       CLOCK_50 = 1'b0;
    logic       RESET = 1'b1;
    logic       LOAD = 1'b0;
    logic [4:0] SUM = '0;

    logic       busy_a, done_a, busy_b, done_b;
    logic [6:0] hex1_a, hex0_a, hex1_b, hex0_b;

    int total = 0;
    int bad = 0;

    sum_display #(.BLANK_LEADING(1)) dut_a (
        .CLOCK_50(CLOCK_50), .RESET(RESET), .SUM(SUM), .LOAD(LOAD),
        .BUSY(busy_a), .DONE(done_a), .HEX1(hex1_a), .HEX0(hex0_a)
    );

    sum_display #(.BLANK_LEADING(0)) dut_b (
        .CLOCK_50(CLOCK_50), .RESET(RESET), .SUM(SUM), .LOAD(LOAD),
        .BUSY(busy_b), .DONE(done_b), .HEX1(hex1_b), .HEX0(hex0_b)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic logic [6:0] exp_tens(input int s, input bit blank);
        if (blank && (s / 10) == 0) return 7'h7F;
        return seg_of(s / 10);
    endfunction

    function automatic logic [6:0] exp_units(input int s);
        return seg_of(s % 10);
    endfunction

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    // Present SUM with LOAD for one edge; returns just after that edge.
    task automatic start_load(input int s);
        SUM  = 5'(s);
        LOAD = 1'b1;
        tick();
        LOAD = 1'b0;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        LOAD  = 1'b0;
        tick();
        tick();
        total++; if ({busy_a, done_a, busy_b, done_b} !== 4'b0000) begin bad++; $display("FAIL reset_flags got=%b exp=0000", {busy_a, done_a, busy_b, done_b}); end
        total++; if ({hex1_a, hex0_a} !== {7'h7F, 7'h7F}) begin bad++; $display("FAIL reset_hex_a got=%h/%h exp=7f/7f", hex1_a, hex0_a); end
        total++; if ({hex1_b, hex0_b} !== {7'h7F, 7'h7F}) begin bad++; $display("FAIL reset_hex_b got=%h/%h exp=7f/7f", hex1_b, hex0_b); end
        RESET = 1'b0;
        tick();
    endtask

    task automatic test_directed();
        int tab[4] = '{23, 0, 31, 9};
        foreach (tab[n]) begin
            int s = tab[n];
            start_load(s);
            total++; if ({busy_a, done_a} !== 2'b10) begin bad++; $display("FAIL dir_busy_k sum=%0d got=%b exp=10", s, {busy_a, done_a}); end
            for (int i = 1; i <= 5; i++) begin
                tick();
                total++; if ({busy_a, done_a} !== 2'b10) begin bad++; $display("FAIL dir_busy sum=%0d edge=k+%0d got=%b exp=10", s, i, {busy_a, done_a}); end
            end
            tick();
            total++; if ({busy_a, done_a, busy_b, done_b} !== 4'b0101) begin bad++; $display("FAIL dir_done sum=%0d got=%b exp=0101", s, {busy_a, done_a, busy_b, done_b}); end
            total++; if (hex1_a !== exp_tens(s, 1'b1)) begin bad++; $display("FAIL dir_hex1_blank sum=%0d got=%b exp=%b", s, hex1_a, exp_tens(s, 1'b1)); end
            total++; if (hex0_a !== exp_units(s)) begin bad++; $display("FAIL dir_hex0 sum=%0d got=%b exp=%b", s, hex0_a, exp_units(s)); end
            total++; if (hex1_b !== exp_tens(s, 1'b0)) begin bad++; $display("FAIL dir_hex1_noblank sum=%0d got=%b exp=%b", s, hex1_b, exp_tens(s, 1'b0)); end
            total++; if (hex0_b !== exp_units(s)) begin bad++; $display("FAIL dir_hex0_b sum=%0d got=%b exp=%b", s, hex0_b, exp_units(s)); end
            SUM = 5'(s + 7);
            tick();
            total++; if (done_a !== 1'b0) begin bad++; $display("FAIL dir_done_pulse sum=%0d got=%b exp=0", s, done_a); end
            total++; if ({hex1_a, hex0_a} !== {exp_tens(s, 1'b1), exp_units(s)}) begin bad++; $display("FAIL dir_hold sum=%0d got=%b/%b", s, hex1_a, hex0_a); end
        end
    endtask

    task automatic test_ignore_load();
        int ndone = 0;
        int done_at = -1;
        start_load(10);
        tick();
        tick();
        SUM  = 5'd31;
        LOAD = 1'b1;
        tick();
        LOAD = 1'b0;
        SUM  = 5'd0;
        total++; if (busy_a !== 1'b1) begin bad++; $display("FAIL ign_busy got=%b exp=1", busy_a); end
        for (int c = 4; c <= 12; c++) begin
            tick();
            if (done_a === 1'b1) begin ndone++; done_at = c; end
        end
        total++; if (ndone !== 1) begin bad++; $display("FAIL ign_done_count got=%0d exp=1", ndone); end
        total++; if (done_at !== 6) begin bad++; $display("FAIL ign_done_cycle got=k+%0d exp=k+6", done_at); end
        total++; if ({hex1_a, hex0_a} !== {seg_of(1), seg_of(0)}) begin bad++; $display("FAIL ign_hex got=%b/%b exp=%b/%b", hex1_a, hex0_a, seg_of(1), seg_of(0)); end
    endtask

    task automatic test_reset_abort();
        int ndone = 0;
        start_load(15);
        tick();
        tick();
        RESET = 1'b1;
        #1;
        total++; if ({busy_a, done_a} !== 2'b00) begin bad++; $display("FAIL abort_flags got=%b exp=00", {busy_a, done_a}); end
        total++; if ({hex1_a, hex0_a, hex1_b, hex0_b} !== {4{7'h7F}}) begin bad++; $display("FAIL abort_hex got=%h/%h/%h/%h exp=7f", hex1_a, hex0_a, hex1_b, hex0_b); end
        tick();
        RESET = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (done_a === 1'b1 || busy_a === 1'b1) ndone++;
        end
        total++; if (ndone !== 0) begin bad++; $display("FAIL abort_no_done got=%0d exp=0", ndone); end
        total++; if ({hex1_a, hex0_a} !== {7'h7F, 7'h7F}) begin bad++; $display("FAIL abort_hex_held got=%h/%h exp=7f/7f", hex1_a, hex0_a); end
        start_load(15);
        repeat (5) tick();
        total++; if (done_a !== 1'b0) begin bad++; $display("FAIL abort_early_done got=%b exp=0", done_a); end
        tick();
        total++; if (done_a !== 1'b1) begin bad++; $display("FAIL abort_relaunch_done got=%b exp=1", done_a); end
        total++; if ({hex1_a, hex0_a} !== {seg_of(1), seg_of(5)}) begin bad++; $display("FAIL abort_relaunch_hex got=%b/%b exp=%b/%b", hex1_a, hex0_a, seg_of(1), seg_of(5)); end
    endtask

    task automatic test_back_to_back();
        start_load(12);
        repeat (5) tick();
        tick();
        total++; if (done_a !== 1'b1) begin bad++; $display("FAIL b2b_done1 got=%b exp=1", done_a); end
        total++; if ({hex1_a, hex0_a} !== {seg_of(1), seg_of(2)}) begin bad++; $display("FAIL b2b_hex1 got=%b/%b exp=%b/%b", hex1_a, hex0_a, seg_of(1), seg_of(2)); end
        start_load(20);
        total++; if ({busy_a, done_a} !== 2'b10) begin bad++; $display("FAIL b2b_accept got=%b exp=10", {busy_a, done_a}); end
        repeat (5) tick();
        tick();
        total++; if (done_a !== 1'b1) begin bad++; $display("FAIL b2b_done2 got=%b exp=1", done_a); end
        total++; if ({hex1_a, hex0_a} !== {seg_of(2), seg_of(0)}) begin bad++; $display("FAIL b2b_hex2 got=%b/%b exp=%b/%b", hex1_a, hex0_a, seg_of(2), seg_of(0)); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 24; n++) begin
            int s = int'($urandom_range(31, 0));
            int gap = int'($urandom_range(3, 0));
            int done_at = -1;
            int ndone = 0;
            repeat (gap) tick();
            start_load(s);
            for (int c = 1; c <= 6; c++) begin
                SUM = 5'($urandom_range(31, 0));
                LOAD = 1'($urandom_range(1, 0));
                tick();
                if (done_a === 1'b1) begin ndone++; done_at = c; end
            end
            LOAD = 1'b0;
            total++; if (ndone !== 1 || done_at !== 6) begin bad++; $display("FAIL rnd_done sum=%0d count=%0d at=k+%0d exp=1 at k+6", s, ndone, done_at); end
            total++; if ({hex1_a, hex0_a} !== {exp_tens(s, 1'b1), exp_units(s)}) begin bad++; $display("FAIL rnd_hex_a sum=%0d got=%b/%b exp=%b/%b", s, hex1_a, hex0_a, exp_tens(s, 1'b1), exp_units(s)); end
            total++; if ({hex1_b, hex0_b} !== {exp_tens(s, 1'b0), exp_units(s)}) begin bad++; $display("FAIL rnd_hex_b sum=%0d got=%b/%b exp=%b/%b", s, hex1_b, hex0_b, exp_tens(s, 1'b0), exp_units(s)); end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignore_load();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sum_display.md
SUM_DISPLAY -- requirements
Module: sum_display

Interface
REQ-001 The block SHALL have one parameter: BLANK_LEADING, default 1, where 1 blanks the tens digit when it is zero.
REQ-002 Ports SHALL be, in order (clock and reset first):
- CLOCK_50  input   1  sole clock; all state updates on its rising edge
- RESET     input   1  asynchronous, active-high reset
- SUM       input   5  adder result; SUM[4] is carry-out, SUM[3:0] is the sum bits (range 0..31)
- LOAD      input   1  single-cycle request to capture SUM
- BUSY      output  1  high while a conversion is in progress
- DONE      output  1  one-cycle pulse when the displays update
- HEX1      output  7  tens digit, active-low segments, bit0=a .. bit6=g
- HEX0      output  7  units digit, same encoding
REQ-003 The block SHALL use one clock; reset SHALL be asynchronous and active-high.

Function
REQ-004 The block SHALL implement an FSM with three states: IDLE, SHIFT and FINISH.
REQ-005 In IDLE with LOAD=1 at edge k, the block SHALL capture SUM into a 5-bit shift register, clear an 8-bit BCD register and the shift counter, and enter SHIFT.
REQ-006 In SHIFT, each edge SHALL perform one double-dabble step:
- add 3 to each BCD nibble that is >=5;
- shift {BCD, shift register} left by 1;
- increment the counter.
REQ-007 After the 5th shift (edge k+5) the block SHALL enter FINISH.
REQ-008 At edge k+6, in FINISH, the block SHALL:
- load HEX1 and HEX0 from the decoded BCD nibbles;
- assert DONE for exactly that one cycle;
- return to IDLE.
REQ-009 Total latency SHALL be 6 cycles, from the LOAD edge to the HEX/DONE update.
REQ-010 BUSY SHALL equal (state != IDLE); it SHALL be registered and never combinationally depend on LOAD.
REQ-011 LOAD SHALL be ignored in SHIFT and FINISH; only the value of SUM captured at acceptance is converted.
REQ-012 A LOAD in the cycle immediately after DONE (state IDLE) SHALL be accepted, giving a back-to-back throughput of one conversion per 7 cycles.
REQ-013 The tens digit SHALL be 0..3 and the units digit 0..9.
REQ-014 When BLANK_LEADING=1 and tens=0, HEX1 SHALL be 7'h7F (blank).
REQ-015 Segment codes SHALL be:
- 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
- 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- any nibble >9 SHALL decode to 7'h7F
REQ-016 HEX1 and HEX0 SHALL hold their values between conversions and SHALL change only at FINISH.

Reset
REQ-017 While RESET=1, regardless of CLOCK_50, the block SHALL force:
- state=IDLE, BUSY=0, DONE=0;
- HEX1=HEX0=7'h7F;
- shift register, BCD register and counter = 0.
REQ-018 A reset asserted mid-conversion SHALL abort it with no DONE pulse and no display update.
REQ-019 After RESET deasserts, the first edge with LOAD=1 SHALL be accepted normally.

Structure
REQ-020 Package sum_display_pkg SHALL hold:
- the state enum (IDLE, SHIFT, FINISH);
- NUM_SHIFTS=5;
- the digit segment constants;
- SEG_BLANK=7'h7F.
REQ-021 Seven-segment decoding SHALL be a combinational sub-module seg7_decode (4-bit in, 7-bit active-low out), instantiated twice.
REQ-022 All outputs SHALL be driven from registers.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- SUM=5'b10111 (23), LOAD pulse at edge k -> BUSY high k+1..k+6; at edge k+6 HEX1=0100100, HEX0=0110000, DONE=1 for one cycle.
- SUM=0, BLANK_LEADING=1 -> HEX1=7F, HEX0=1000000; repeat with BLANK_LEADING=0 -> HEX1=1000000.
- SUM=31 -> HEX1=0110000, HEX0=1111001; SUM=9 -> HEX1=7F, HEX0=0010000.
- LOAD=1 with SUM=10 at edge k, then LOAD=1 with SUM=31 at edge k+3 -> second request ignored; display shows 1,0; exactly one DONE.
- SUM=15, LOAD, then RESET asserted at k+3 -> immediately BUSY=0 and HEX=7F/7F; no DONE pulse; a subsequent LOAD with SUM=15 shows 1,5 six cycles later.
- Back-to-back: LOAD at k (SUM=12) and LOAD at k+7 (SUM=20) -> DONE at k+6 (1,2) and at k+13 (2,0).
